sign_extend_16_to_32: RTL and testbench
=======================================

# sign_extend_16_to_32

Immediate-extension unit for the single-cycle MIPS datapath. It widens a 16-bit instruction immediate to 32 bits.
- The combinational output `bit_32` feeds the ALU-B mux and the branch adder in the same cycle.
- A registered, mode-selectable path (sign, zero, LUI, branch-offset) with valid tracking serves pipelined or multi-cycle variants of the core.
- Port order for positional instantiation is `bit_32`, `bit_16`, then the remaining ports as listed below.

## Interface
Parameters: none. Widths are fixed at 16 in and 32 out.

Ports:
- `clk`  input  1  single clock; all registers update on its rising edge.
- `rst`  input  1  reset, synchronous and active-high; sampled only on the `clk` rising edge.
- `bit_32`  output  32  combinational sign extension of `bit_16`.
- `bit_16`  input  16  immediate field, instruction bits [15:0].
- `mode`  input  2  extension mode for the registered path:
  - 00: sign
  - 01: zero
  - 10: LUI
  - 11: branch offset
- `in_valid`  input  1  qualifies `bit_16` and `mode` for the registered path.
- `ext_q`  output  32  registered extension result.
- `out_valid`  output  1  `ext_q` holds a result captured from a valid input.
- `neg_q`  output  1  registered copy of `ext_q[31]`.
- `zero_q`  output  1  registered flag, high when `ext_q == 0`.

## Operation
Combinational path:
- `bit_32 = {{16{bit_16[15]}}, bit_16}` at all times.
- Independent of `clk`, `rst`, `mode` and `in_valid`.
- Bits [15:0] equal `bit_16`; bits [31:16] are copies of `bit_16[15]`.

Registered path, computed result `ext_d` by mode:
- 00 sign: `{{16{bit_16[15]}}, bit_16}`, identical to `bit_32`.
- 01 zero: `{16'h0000, bit_16}`.
- 10 LUI: `{bit_16, 16'h0000}`.
- 11 branch offset: `{{14{bit_16[15]}}, bit_16, 2'b00}`. This is the sign extension shifted left by 2. Bits that overflow past bit 31 are discarded and no overflow is flagged.

Update rules on each rising edge of `clk`:
- When `rst` = 1: `ext_q`, `out_valid`, `neg_q` and `zero_q` all go to 0. Reset takes priority over `in_valid`.
- When `rst` = 0 and `in_valid` = 1:
  - `ext_q` ← `ext_d`
  - `neg_q` ← `ext_d[31]`
  - `zero_q` ← (`ext_d == 0`)
  - `out_valid` ← 1
- When `rst` = 0 and `in_valid` = 0:
  - `ext_q`, `neg_q` and `zero_q` hold their values.
  - `out_valid` ← 0.

General rules:
- No state machine; the block is one pipeline stage with no backpressure.
- No X propagation from `mode` when `in_valid` = 0.
- All four mode encodings are legal; none are reserved.

## Timing
- `bit_32`: zero-cycle latency, purely combinational. It settles within the same delta as `bit_16` changes and is valid with no clock running.
- Registered path: 1-cycle latency. An input accepted at edge N appears on `ext_q`, `out_valid`, `neg_q` and `zero_q` after edge N.
- Throughput: one result per cycle. Back-to-back `in_valid` cycles each overwrite the previous result.
- Reset mid-stream: a valid input coincident with `rst` = 1 is dropped. Outputs read 0 and `out_valid` reads 0 after that edge.
- First valid capture after reset release: the cycle following the first edge where `rst` = 0 and `in_valid` = 1.
- The combinational path is unaffected during reset. `bit_32` tracks `bit_16` while `rst` = 1.

## Test plan
- Combinational, positive input: `bit_16` = 0x0AC1 → `bit_32` = 0x00000AC1. Repeat with 0x4000 → 0x00004000. Hold each value 20 time units with no clock.
- Combinational, negative input: `bit_16` = 0xEA81 → `bit_32` = 0xFFFFEA81. Repeat with 0xC000 → 0xFFFFC000. Boundaries: 0x7FFF → 0x00007FFF; 0x8000 → 0xFFFF8000.
- Registered modes with `bit_16` = 0xC000 and `in_valid` = 1, checked one edge later:
  - mode 00 → `ext_q` = 0xFFFFC000, `neg_q` = 1
  - mode 01 → 0x0000C000, `neg_q` = 0
  - mode 10 → 0xC0000000, `neg_q` = 1
  - mode 11 → 0xFFFF0000, `neg_q` = 1
- Flags and hold:
  - `bit_16` = 0x0000, mode 10, valid → `ext_q` = 0, `zero_q` = 1.
  - Next cycle `in_valid` = 0 → `out_valid` = 0 and `ext_q` holds 0.
- Reset: after a capture of 0xFFFFEA81, assert `rst` together with `in_valid` = 1 and `bit_16` = 0x1234.
  - After that edge: `ext_q` = 0, `out_valid` = 0, `neg_q` = 0, `zero_q` = 0.
  - `bit_32` = 0x00001234 throughout.
- Back-to-back inputs: 0x0AC1, 0xEA81, 0x4000 in mode 00 on consecutive edges → `ext_q` sequence 0x00000AC1, 0xFFFFEA81, 0x00004000, with `out_valid` held at 1.

Source files
------------

// File: rtl/sign_extend_16_to_32.sv
// Immediate extension for the MIPS datapath.
// bit_32 is the combinational sign extension of the 16-bit immediate and feeds
// the ALU-B mux and the branch adder. A single registered stage offers sign,
// zero, LUI and branch-offset extension with valid tracking and result flags.
`timescale 1ns/1ps

module sign_extend_16_to_32 (
  output logic [31:0] bit_32,
  input  logic [15:0] bit_16,
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        in_valid,
  output logic [31:0] ext_q,
  output logic        out_valid,
  output logic        neg_q,
  output logic        zero_q
);

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_LUI    = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  logic [31:0] ext_res;
  logic [31:0] ext_d;
  logic        neg_d;
  logic        zero_d;
  logic        out_valid_d;
  logic        out_valid_q;

  // Same-cycle sign extension; independent of clock, reset and mode.
  assign bit_32 = {{16{bit_16[15]}}, bit_16};

  // Select the extension for the registered path by mode.
  always_comb begin
    ext_res = bit_32;
    case (mode)
      MODE_SIGN:   ext_res = bit_32;
      MODE_ZERO:   ext_res = {16'h0000, bit_16};
      MODE_LUI:    ext_res = {bit_16, 16'h0000};
      MODE_BRANCH: ext_res = {{14{bit_16[15]}}, bit_16, 2'b00};
      default:     ext_res = bit_32;
    endcase
  end

  // Capture on a valid input, otherwise hold the result and drop valid.
  // The mode mux output is only used when in_valid is high, so an unknown
  // mode while idle cannot reach the registers.
  always_comb begin
    ext_d       = ext_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      ext_d       = ext_res;
      neg_d       = ext_res[31];
      zero_d      = (ext_res == 32'h0000_0000);
      out_valid_d = 1'b1;
    end
  end

  // Result registers; synchronous reset wins over an incoming valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q       <= 32'h0000_0000;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extend_16_to_32.sv
// Self-checking bench for sign_extend_16_to_32: directed cases plus a
// randomized sequence checked against an arithmetic reference model.
`timescale 1ns/1ps

module tb_sign_extend_16_to_32;

  logic [31:0] bit_32;
  logic [15:0] bit_16;
  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic [31:0] ext_q;
  logic        out_valid;
  logic        neg_q;
  logic        zero_q;

  int checks = 0;
  int errors = 0;
  logic clk_en = 1'b0;

  // Expected registered state, maintained by the model.
  logic [31:0] e_ext;
  logic        e_vld, e_neg, e_zero;

  sign_extend_16_to_32 dut (
    .bit_32   (bit_32),
    .bit_16   (bit_16),
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .in_valid (in_valid),
    .ext_q    (ext_q),
    .out_valid(out_valid),
    .neg_q    (neg_q),
    .zero_q   (zero_q)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  function automatic logic [31:0] sext(input logic [15:0] b);
    int s;
    s = $signed(b);
    return 32'(s);
  endfunction

  function automatic logic [31:0] ref_ext(input logic [15:0] b, input logic [1:0] m);
    int          s;
    logic [31:0] u;
    s = $signed(b);
    u = 32'(b);
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return u;
      2'd2:    return u * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [15:0] b, input logic [1:0] m,
                      input logic v, input logic r);
    @(negedge clk);
    bit_16 = b; mode = m; in_valid = v; rst = r;
    #1 chk("bit_32_pre", bit_32, sext(b));
    @(posedge clk);
    if (r) begin
      e_ext = '0; e_vld = 1'b0; e_neg = 1'b0; e_zero = 1'b0;
    end else if (v) begin
      e_ext  = ref_ext(b, m);
      e_vld  = 1'b1;
      e_neg  = e_ext[31];
      e_zero = (e_ext == 0);
    end else begin
      e_vld = 1'b0;
    end
    #1;
    chk("ext_q", ext_q, e_ext);
    chk("out_valid", 32'(out_valid), 32'(e_vld));
    chk("neg_q", 32'(neg_q), 32'(e_neg));
    chk("zero_q", 32'(zero_q), 32'(e_zero));
  endtask

  initial begin
    logic [15:0] comb_vals [6];
    logic [15:0] rb;
    logic [1:0]  rm;
    logic        rv, rr;

    rst = 1'b1; in_valid = 1'b0; mode = 2'b00; bit_16 = 16'h0000;
    e_ext = '0; e_vld = 1'b0; e_neg = 1'b0; e_zero = 1'b0;

    // Combinational path with no clock running.
    comb_vals = '{16'h0AC1, 16'h4000, 16'hEA81, 16'hC000, 16'h7FFF, 16'h8000};
    foreach (comb_vals[i]) begin
      bit_16 = comb_vals[i];
      #20 chk("comb", bit_32, sext(comb_vals[i]));
    end
    bit_16 = 16'h7FFF; #1 chk("comb_7fff", bit_32, 32'h0000_7FFF);
    bit_16 = 16'h8000; #1 chk("comb_8000", bit_32, 32'hFFFF_8000);
    bit_16 = 16'hEA81; #1 chk("comb_ea81", bit_32, 32'hFFFF_EA81);

    // Start the clock and apply reset.
    clk_en = 1'b1;
    step(16'h0000, 2'b00, 1'b0, 1'b1);
    step(16'h5555, 2'b01, 1'b1, 1'b1);
    chk("reset_ext", ext_q, 32'h0);
    chk("reset_vld", 32'(out_valid), 32'h0);

    // All four modes on 0xC000.
    step(16'hC000, 2'b00, 1'b1, 1'b0);
    chk("m00_ext", ext_q, 32'hFFFF_C000); chk("m00_neg", 32'(neg_q), 32'h1);
    step(16'hC000, 2'b01, 1'b1, 1'b0);
    chk("m01_ext", ext_q, 32'h0000_C000); chk("m01_neg", 32'(neg_q), 32'h0);
    step(16'hC000, 2'b10, 1'b1, 1'b0);
    chk("m10_ext", ext_q, 32'hC000_0000); chk("m10_neg", 32'(neg_q), 32'h1);
    step(16'hC000, 2'b11, 1'b1, 1'b0);
    chk("m11_ext", ext_q, 32'hFFFF_0000); chk("m11_neg", 32'(neg_q), 32'h1);

    // Zero flag and hold with in_valid low.
    step(16'h0000, 2'b10, 1'b1, 1'b0);
    chk("zero_ext", ext_q, 32'h0); chk("zero_flag", 32'(zero_q), 32'h1);
    step(16'hFFFF, 2'b11, 1'b0, 1'b0);
    chk("hold_vld", 32'(out_valid), 32'h0); chk("hold_ext", ext_q, 32'h0);

    // Reset coincident with a valid input drops it.
    step(16'hEA81, 2'b00, 1'b1, 1'b0);
    chk("pre_rst_ext", ext_q, 32'hFFFF_EA81);
    step(16'h1234, 2'b00, 1'b1, 1'b1);
    chk("rst_ext", ext_q, 32'h0);
    chk("rst_vld", 32'(out_valid), 32'h0);
    chk("rst_neg", 32'(neg_q), 32'h0);
    chk("rst_zero", 32'(zero_q), 32'h0);
    chk("rst_bit32", bit_32, 32'h0000_1234);

    // Back-to-back captures in sign mode.
    step(16'h0AC1, 2'b00, 1'b1, 1'b0);
    chk("b2b0", ext_q, 32'h0000_0AC1); chk("b2b0_vld", 32'(out_valid), 32'h1);
    step(16'hEA81, 2'b00, 1'b1, 1'b0);
    chk("b2b1", ext_q, 32'hFFFF_EA81); chk("b2b1_vld", 32'(out_valid), 32'h1);
    step(16'h4000, 2'b00, 1'b1, 1'b0);
    chk("b2b2", ext_q, 32'h0000_4000); chk("b2b2_vld", 32'(out_valid), 32'h1);

    // Randomized traffic, including occasional zero immediates and resets.
    for (int i = 0; i < 300; i++) begin
      rb = 16'($urandom);
      if ($urandom_range(0, 9) == 0) rb = 16'h0000;
      rm = 2'($urandom_range(0, 3));
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 19) == 0);
      step(rb, rm, rv, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
